// File: rtl/jtgng_sdram_ctrl.sv
// jtgng_sdram_ctrl: SDRAM command sequencer for the ROM slot scheduler.
//
// Runs the power-up init (NOP wait, precharge-all, two refreshes, mode register).
// After init it serves one request per 4-clock slot: a single-word read or a
// refresh while playing, and writes while downloading. Every access uses
// auto-precharge, CL = 2, burst = 1, and bank 0 only.
//
// Ports:
//   clk, rst            48 MHz clock, synchronous active-high reset
//   start, addr         slot strobe and {row[12:0], col[8:0]} read address
//   autorefresh         issue REFRESH instead of READ for this slot
//   downloading         download mode: slot reads ignored, prog writes served
//   prog_addr/data/mask download write word, address and {DQMH,DQML} mask
//   prog_req, prog_ack  write request level / one-cycle ack on the WRITE cycle
//   loop_rst            held high until init completes
//   data_read           registered read data
//   sdram_*             SDRAM address, bank, {nCS,nRAS,nCAS,nWE}, DQM, CKE
//   dq_in/dq_out/dq_oe  DQ bus split into input, output and output enable
//
// Build option: define DOWNLOAD_REFRESH_EN to force a REFRESH every
// REFRESH_PERIOD cycles while downloading. Without it no refresh is issued
// during download.
module jtgng_sdram_ctrl #(
  parameter int unsigned INIT_WAIT      = 9600,
  parameter logic [12:0] MODE_REG       = 13'h020,
  parameter int unsigned REFRESH_PERIOD = 360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [21:0] addr,
  input  logic        autorefresh,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_req,
  output logic        prog_ack,
  output logic        loop_rst,
  output logic [15:0] data_read,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_dqm,
  output logic        sdram_cke,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe
);

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_REF    = 4'b0001;
  localparam logic [3:0] CMD_MRS    = 4'b0000;

  localparam logic [2:0] ST_INIT_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT_PRE  = 3'd1;
  localparam logic [2:0] ST_INIT_REF  = 3'd2;
  localparam logic [2:0] ST_INIT_MRS  = 3'd3;
  localparam logic [2:0] ST_IDLE      = 3'd4;
  localparam logic [2:0] ST_ACT       = 3'd5;
  localparam logic [2:0] ST_WAIT      = 3'd6;

  // Wide enough to reach INIT_WAIT-1 and the short NOP gaps.
  localparam int unsigned CW = (INIT_WAIT > 4) ? $clog2(INIT_WAIT) : 3;
  localparam int unsigned RW = $clog2(REFRESH_PERIOD + 1);

  logic [2:0]    r_st, w_st_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_ref2, w_ref2_nx;
  logic          r_wr, w_wr_nx;
  logic [21:0]   r_addr, w_addr_nx;
  logic [3:0]    r_cmd, w_cmd_nx;
  logic [12:0]   r_a, w_a_nx;
  logic [1:0]    r_dqm, w_dqm_nx;
  logic          r_dq_oe, w_dq_oe_nx;
  logic [15:0]   r_dq_out, w_dq_out_nx;
  logic          r_prog_ack, w_prog_ack_nx;
  logic          r_loop_rst, w_loop_rst_nx;
  logic          r_cke;
  logic [15:0]   r_data_read;
  logic [2:0]    r_rd_sh;
  logic [RW-1:0] r_dl_cnt;
  logic          w_ref_due;
  logic          w_ref_issue;
  logic          w_rd_issue;

`ifdef DOWNLOAD_REFRESH_EN
  assign w_ref_due = (r_dl_cnt == RW'(REFRESH_PERIOD));
`else
  assign w_ref_due = 1'b0;
`endif

  always_comb begin
    w_st_nx       = r_st;
    w_cnt_nx      = r_cnt + CW'(1);
    w_ref2_nx     = r_ref2;
    w_wr_nx       = r_wr;
    w_addr_nx     = r_addr;
    w_cmd_nx      = CMD_NOP;
    w_a_nx        = r_a;
    w_dqm_nx      = 2'b11;
    w_dq_oe_nx    = 1'b0;
    w_dq_out_nx   = r_dq_out;
    w_prog_ack_nx = 1'b0;
    w_loop_rst_nx = r_loop_rst;
    w_ref_issue   = 1'b0;
    w_rd_issue    = 1'b0;
    unique case (r_st)
      ST_INIT_WAIT: begin
        if (r_cnt == CW'(INIT_WAIT - 1)) begin
          w_cmd_nx = CMD_PRE;
          w_a_nx   = 13'h0400;  // a[10]: precharge all banks
          w_st_nx  = ST_INIT_PRE;
          w_cnt_nx = '0;
        end
      end
      ST_INIT_PRE: begin
        if (r_cnt == CW'(2)) begin
          w_cmd_nx  = CMD_REF;
          w_st_nx   = ST_INIT_REF;
          w_cnt_nx  = '0;
          w_ref2_nx = 1'b0;
        end
      end
      ST_INIT_REF: begin
        if (r_cnt == CW'(3)) begin
          w_cnt_nx = '0;
          if (!r_ref2) begin
            w_cmd_nx  = CMD_REF;
            w_ref2_nx = 1'b1;
          end else begin
            w_cmd_nx = CMD_MRS;
            w_a_nx   = MODE_REG;
            w_st_nx  = ST_INIT_MRS;
          end
        end
      end
      ST_INIT_MRS: begin
        if (r_cnt == CW'(2)) begin
          w_st_nx       = ST_IDLE;
          w_cnt_nx      = '0;
          w_loop_rst_nx = 1'b0;
        end
      end
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (!r_loop_rst) begin
          if (w_ref_due) begin
            w_cmd_nx    = CMD_REF;
            w_st_nx     = ST_WAIT;
            w_ref_issue = 1'b1;
          end else if (downloading) begin
            if (prog_req) begin
              w_cmd_nx  = CMD_ACTIVE;
              w_a_nx    = prog_addr[21:9];
              w_addr_nx = prog_addr;
              w_wr_nx   = 1'b1;
              w_st_nx   = ST_ACT;
            end
          end else if (start) begin
            if (autorefresh) begin
              w_cmd_nx = CMD_REF;
              w_st_nx  = ST_WAIT;
            end else begin
              w_cmd_nx  = CMD_ACTIVE;
              w_a_nx    = addr[21:9];
              w_addr_nx = addr;
              w_wr_nx   = 1'b0;
              w_st_nx   = ST_ACT;
            end
          end
        end
      end
      ST_ACT: begin
        w_a_nx  = {4'b0010, r_addr[8:0]};  // a[10]: auto-precharge
        w_st_nx = ST_WAIT;
        if (r_wr) begin
          w_cmd_nx      = CMD_WRITE;
          w_dqm_nx      = prog_mask;
          w_dq_oe_nx    = 1'b1;
          w_dq_out_nx   = prog_data;
          w_prog_ack_nx = 1'b1;
          w_cnt_nx      = '0;       // two NOPs after WRITE
        end else begin
          w_cmd_nx   = CMD_READ;
          w_dqm_nx   = 2'b00;
          w_rd_issue = 1'b1;
          w_cnt_nx   = CW'(1);      // one NOP after READ keeps the 4-clk slot
        end
      end
      ST_WAIT: begin
        if (r_cnt == CW'(2)) begin
          w_st_nx  = ST_IDLE;
          w_cnt_nx = '0;
        end
      end
      default: begin
        w_st_nx  = ST_INIT_WAIT;
        w_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= ST_INIT_WAIT;
      r_cnt       <= '0;
      r_ref2      <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_cmd       <= CMD_NOP;
      r_a         <= '0;
      r_dqm       <= 2'b11;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
      r_prog_ack  <= 1'b0;
      r_loop_rst  <= 1'b1;
      r_cke       <= 1'b1;
      r_data_read <= '0;
      r_rd_sh     <= '0;
    end else begin
      r_st       <= w_st_nx;
      r_cnt      <= w_cnt_nx;
      r_ref2     <= w_ref2_nx;
      r_wr       <= w_wr_nx;
      r_addr     <= w_addr_nx;
      r_cmd      <= w_cmd_nx;
      r_a        <= w_a_nx;
      r_dqm      <= w_dqm_nx;
      r_dq_oe    <= w_dq_oe_nx;
      r_dq_out   <= w_dq_out_nx;
      r_prog_ack <= w_prog_ack_nx;
      r_loop_rst <= w_loop_rst_nx;
      r_cke      <= 1'b1;
      // Bit 0 marks the READ cycle; with CL2 data is on DQ two cycles later.
      r_rd_sh    <= {r_rd_sh[1:0], w_rd_issue};
      if (r_rd_sh[2]) begin
        r_data_read <= dq_in;
      end
    end
  end

  // Download refresh counter; only consulted when forced refresh is built in.
  always_ff @(posedge clk) begin
    if (rst || !downloading || w_ref_issue) begin
      r_dl_cnt <= '0;
    end else if (r_dl_cnt != RW'(REFRESH_PERIOD)) begin
      r_dl_cnt <= r_dl_cnt + RW'(1);
    end
  end

  assign prog_ack  = r_prog_ack;
  assign loop_rst  = r_loop_rst;
  assign data_read = r_data_read;
  assign sdram_a   = r_a;
  assign sdram_ba  = 2'b00;
  assign sdram_cmd = r_cmd;
  assign sdram_dqm = r_dqm;
  assign sdram_cke = r_cke;
  assign dq_out    = r_dq_out;
  assign dq_oe     = r_dq_oe;

endmodule

// File: tb/tb_jtgng_sdram_ctrl.sv
// Self-checking bench for jtgng_sdram_ctrl: init sequence, read and refresh
// slots, back-to-back slots, download writes, forced download refresh (when
// DOWNLOAD_REFRESH_EN is defined) and reset in the middle of a write.
module tb_jtgng_sdram_ctrl;

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;
  localparam logic [3:0] CMD_PRE    = 4'b0010;
  localparam logic [3:0] CMD_REF    = 4'b0001;
  localparam logic [3:0] CMD_MRS    = 4'b0000;
  localparam logic [15:0] DQ_JUNK   = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] addr;
  logic        autorefresh;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_req;
  logic        prog_ack;
  logic        loop_rst;
  logic [15:0] data_read;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_dqm;
  logic        sdram_cke;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  jtgng_sdram_ctrl #(
    .INIT_WAIT      (9600),
    .MODE_REG       (13'h020),
    .REFRESH_PERIOD (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr        (addr),
    .autorefresh (autorefresh),
    .downloading (downloading),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_req    (prog_req),
    .prog_ack    (prog_ack),
    .loop_rst    (loop_rst),
    .data_read   (data_read),
    .sdram_a     (sdram_a),
    .sdram_ba    (sdram_ba),
    .sdram_cmd   (sdram_cmd),
    .sdram_dqm   (sdram_dqm),
    .sdram_cke   (sdram_cke),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Samples on falling edges until a non-NOP command appears (bounded).
  task automatic next_cmd(output int nops, output logic [3:0] cmd);
    nops = 0;
    cmd  = CMD_NOP;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (sdram_cmd !== CMD_NOP) begin
        cmd = sdram_cmd;
        return;
      end
      nops++;
    end
  endtask

  // Expects rst released #1 after a reset edge; ends on the first IDLE cycle.
  task automatic check_init();
    int          n;
    logic [3:0]  c;
    next_cmd(n, c);
    check_eq("init_wait_nops", n, 9600);
    check_eq("init_pre_cmd", c, CMD_PRE);
    check_eq("init_pre_a10", sdram_a[10], 1'b1);
    next_cmd(n, c);
    check_eq("init_ref1_cmd", c, CMD_REF);
    check_eq("init_pre_gap", n, 2);
    next_cmd(n, c);
    check_eq("init_ref2_cmd", c, CMD_REF);
    check_eq("init_ref1_gap", n, 3);
    next_cmd(n, c);
    check_eq("init_mrs_cmd", c, CMD_MRS);
    check_eq("init_ref2_gap", n, 3);
    check_eq("init_mrs_a", sdram_a, 13'h020);
    check_eq("init_mrs_loop_rst", loop_rst, 1'b1);
    @(negedge clk);
    check_eq("init_mrs_nop1", {sdram_cmd, 3'b000, loop_rst}, {CMD_NOP, 4'b0001});
    @(negedge clk);
    check_eq("init_mrs_nop2", {sdram_cmd, 3'b000, loop_rst}, {CMD_NOP, 4'b0001});
    @(negedge clk);
    check_eq("init_idle_loop_rst", loop_rst, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  exp_cmd [14];
    logic [12:0] exp_a   [14];
    logic [21:0] b2b_addr[14];
    int          n_ack, n_oe, n_wr, n_ref;
    logic [3:0]  cmd_at11, cmd_at15;
    logic        found;

    rst         = 1'b1;
    start       = 1'b0;
    addr        = '0;
    autorefresh = 1'b0;
    downloading = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_mask   = 2'b00;
    prog_req    = 1'b0;
    dq_in       = DQ_JUNK;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cmd", sdram_cmd, CMD_NOP);
    check_eq("rst_cke", sdram_cke, 1'b1);
    check_eq("rst_loop_rst", loop_rst, 1'b1);
    check_eq("rst_data_read", data_read, 16'h0000);
    check_eq("rst_oe_ack", {dq_oe, prog_ack}, 2'b00);
    check_eq("rst_a", sdram_a, 13'h0000);
    check_eq("rst_dqm_ba", {sdram_dqm, sdram_ba}, 4'b1100);

    @(posedge clk);
    #1 rst = 1'b0;
    check_init();

    // Single read slot, t0 = this cycle
    addr  = 22'h0A123;
    start = 1'b1;
    @(negedge clk);  // t0+1
    start = 1'b0;
    check_eq("rd_act_cmd", sdram_cmd, CMD_ACTIVE);
    check_eq("rd_act_row", sdram_a, 13'h0050);
    @(negedge clk);  // t0+2
    check_eq("rd_read_cmd", sdram_cmd, CMD_READ);
    check_eq("rd_read_a", sdram_a, 13'h0523);
    check_eq("rd_read_dqm", sdram_dqm, 2'b00);
    @(negedge clk);  // t0+3
    check_eq("rd_nop_cmd_dqm", {sdram_cmd, 2'b00, sdram_dqm}, {CMD_NOP, 4'b0011});
    @(negedge clk);  // t0+4
    check_eq("rd_not_yet", data_read, 16'h0000);
    dq_in = 16'hBEEF;
    @(negedge clk);  // t0+5
    dq_in = DQ_JUNK;
    check_eq("rd_data", data_read, 16'hBEEF);

    // Refresh slot
    autorefresh = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    autorefresh = 1'b0;
    check_eq("ref_cmd", sdram_cmd, CMD_REF);
    @(negedge clk);
    check_eq("ref_nop1", sdram_cmd, CMD_NOP);
    @(negedge clk);
    check_eq("ref_nop2", sdram_cmd, CMD_NOP);
    @(negedge clk);
    @(negedge clk);
    check_eq("ref_data_kept", data_read, 16'hBEEF);

    // Back-to-back slots at k = 0, 4, 8; stray start at k = 2
    for (int k = 0; k < 14; k++) begin
      exp_cmd[k]  = CMD_NOP;
      exp_a[k]    = '0;
      b2b_addr[k] = '0;
    end
    b2b_addr[0] = 22'h000001;
    b2b_addr[2] = 22'h3FF000;
    b2b_addr[4] = 22'h3FFFFF;
    b2b_addr[8] = 22'h155555;
    exp_cmd[1]  = CMD_ACTIVE; exp_a[1]  = 13'h0000;
    exp_cmd[2]  = CMD_READ;   exp_a[2]  = 13'h0401;
    exp_cmd[5]  = CMD_ACTIVE; exp_a[5]  = 13'h1FFF;
    exp_cmd[6]  = CMD_READ;   exp_a[6]  = 13'h05FF;
    exp_cmd[9]  = CMD_ACTIVE; exp_a[9]  = 13'h0AAA;
    exp_cmd[10] = CMD_READ;   exp_a[10] = 13'h0555;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        check_eq($sformatf("b2b_cmd_%0d", k), sdram_cmd, exp_cmd[k]);
        if (exp_cmd[k] != CMD_NOP) begin
          check_eq($sformatf("b2b_a_%0d", k), sdram_a, exp_a[k]);
        end
      end
      start = (k == 0) || (k == 2) || (k == 4) || (k == 8);
      addr  = b2b_addr[k];
      @(negedge clk);
    end
    start = 1'b0;

    // Download: start ignored, then one masked write
    downloading = 1'b1;
    start       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("dl_start_ignored_%0d", k), sdram_cmd, CMD_NOP);
    end
    start     = 1'b0;
    prog_addr = 22'h00200;
    prog_data = 16'h1234;
    prog_mask = 2'b10;
    prog_req  = 1'b1;
    n_ack = 0;
    n_oe  = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (prog_ack === 1'b1) n_ack++;
      if (dq_oe === 1'b1) n_oe++;
      if (k == 1) begin
        check_eq("wr_act_cmd", sdram_cmd, CMD_ACTIVE);
        check_eq("wr_act_row", sdram_a, 13'h0001);
      end
      if (k == 2) begin
        check_eq("wr_cmd", sdram_cmd, CMD_WRITE);
        check_eq("wr_a", sdram_a, 13'h0400);
        check_eq("wr_oe_ack", {dq_oe, prog_ack}, 2'b11);
        check_eq("wr_dq_out", dq_out, 16'h1234);
        check_eq("wr_dqm", sdram_dqm, 2'b10);
        prog_req = 1'b0;
      end
      if (k == 3) begin
        check_eq("wr_nop_cmd", sdram_cmd, CMD_NOP);
        check_eq("wr_nop_dqm", sdram_dqm, 2'b11);
        downloading = 1'b0;
      end
      if (k >= 4) begin
        check_eq($sformatf("wr_tail_%0d", k), sdram_cmd, CMD_NOP);
      end
    end
    check_eq("wr_ack_pulses", n_ack, 1);
    check_eq("wr_oe_cycles", n_oe, 1);

    // Long download with prog_req held high
    prog_addr   = 22'h001234;
    prog_data   = 16'hCAFE;
    prog_mask   = 2'b00;
    downloading = 1'b1;
    prog_req    = 1'b1;
    n_wr  = 0;
    n_ref = 0;
    n_ack = 0;
    cmd_at11 = CMD_NOP;
    cmd_at15 = CMD_NOP;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sdram_cmd === CMD_WRITE) n_wr++;
      if (sdram_cmd === CMD_REF) n_ref++;
      if (prog_ack === 1'b1) n_ack++;
      if (k == 11) cmd_at11 = sdram_cmd;
      if (k == 15) cmd_at15 = sdram_cmd;
    end
`ifdef DOWNLOAD_REFRESH_EN
    check_eq("dl_forced_ref_at11", cmd_at11, CMD_REF);
    check_eq("dl_act_after_ref", cmd_at15, CMD_ACTIVE);
    check_eq("dl_writes", n_wr, 5);
    check_eq("dl_refreshes", n_ref, 4);
    check_eq("dl_acks", n_ack, 5);
`else
    check_eq("dl_act_at11", cmd_at11, CMD_ACTIVE);
    check_eq("dl_idle_at15", cmd_at15, CMD_NOP);
    check_eq("dl_writes", n_wr, 8);
    check_eq("dl_refreshes", n_ref, 0);
    check_eq("dl_acks", n_ack, 8);
`endif

    // Reset in the middle of a write
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!found) begin
        @(negedge clk);
        if (sdram_cmd === CMD_ACTIVE) found = 1'b1;
      end
    end
    check_eq("midrst_found_act", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_cmd", sdram_cmd, CMD_NOP);
    check_eq("midrst_oe_ack", {dq_oe, prog_ack}, 2'b00);
    check_eq("midrst_loop_rst", loop_rst, 1'b1);
    check_eq("midrst_dqm", sdram_dqm, 2'b11);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    downloading = 1'b0;
    prog_req    = 1'b0;
    check_init();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
